// File: rtl/lcm_pkg.sv
// Shared types, field positions and beat builders for the LCM register-access controller.
package lcm_pkg;

    localparam int unsigned LCM_W  = 134;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;

    // Beat field positions
    localparam int unsigned TYPE_HI     = 133;
    localparam int unsigned TYPE_LO     = 132;
    localparam int unsigned REG_HI      = 127;
    localparam int unsigned REG_LO      = 120;
    localparam int unsigned VAL_HI      = 119;
    localparam int unsigned VAL_LO      = 56;
    localparam int unsigned RD_FLAG_BIT = 48;

    localparam logic [1:0] BEAT_HEAD = 2'b01;
    localparam logic [1:0] BEAT_BODY = 2'b11;
    localparam logic [1:0] BEAT_TAIL = 2'b10;

    localparam logic [DATA_W-1:0] TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUS       = 2'd1,
        ST_RESP_HDR  = 2'd2,
        ST_RESP_DATA = 2'd3
    } state_e;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    function automatic logic [LCM_W-1:0] make_hdr_beat(input logic [ADDR_W-1:0] lmid,
                                                       input logic [ADDR_W-1:0] addr);
        logic [LCM_W-1:0] beat;
        beat                     = '0;
        beat[TYPE_HI:TYPE_LO]    = BEAT_HEAD;
        beat[REG_HI:REG_LO]      = lmid;
        beat[VAL_HI -: ADDR_W]   = addr;
        beat[RD_FLAG_BIT]        = 1'b1;
        return beat;
    endfunction

    function automatic logic [LCM_W-1:0] make_data_beat(input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
        logic [LCM_W-1:0] beat;
        beat                     = '0;
        beat[TYPE_HI:TYPE_LO]    = BEAT_TAIL;
        beat[REG_HI:REG_LO]      = addr;
        beat[VAL_HI:VAL_LO]      = data;
        return beat;
    endfunction

endpackage

// File: rtl/lcm_cmd_fifo.sv
// Single-clock command FIFO; extra pointer bit separates full from empty.
module lcm_cmd_fifo #(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/lcm_reg_ctrl.sv
// Queues LCM register commands, runs them one at a time on the register bus,
// and returns read results as a two-beat LCM response.
module lcm_reg_ctrl
    import lcm_pkg::*;
#(
    parameter logic [7:0]  LMID       = 8'd3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] TIMEOUT    = 16'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_reg_n,
    input  logic [63:0]       wr_reg_n_value,
    input  logic [7:0]        rd_reg_n,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [7:0]        bus_addr,
    output logic [63:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [63:0]       bus_rdata,
    output logic [133:0]      out_lcm_data,
    output logic              out_lcm_data_wr,
    output logic              out_lcm_data_valid,
    output logic              out_lcm_data_valid_wr,
    input  logic              out_lcm_data_ready,
    output logic              cmd_drop,
    output logic              busy
);

    state_e state_q, state_d;

    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    cmd_t              head_c;
    cmd_t              push_cmd_c;
    logic              push_c;
    logic              drop_c;
    logic              pop_c;
    logic              ack_c;
    logic              tmo_c;

    logic              bus_req_q,   bus_req_d;
    logic              bus_wr_q,    bus_wr_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              timeout_q,   timeout_d;
    logic [LCM_W-1:0]  out_data_q,  out_data_d;
    logic              out_wr_q,    out_wr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_vwr_q,   out_vwr_d;
    logic              cmd_drop_q,  cmd_drop_d;

    // Command decode: a write wins over a simultaneous read; full drops regardless of pop.
    always_comb begin
        push_cmd_c = '0;
        push_c     = 1'b0;
        drop_c     = 1'b0;
        if (wr_reg_n != '0) begin
            push_cmd_c.is_wr = 1'b1;
            push_cmd_c.addr  = wr_reg_n;
            push_cmd_c.wdata = wr_reg_n_value;
            push_c           = 1'b1;
            drop_c           = (rd_reg_n != '0);
        end else if (rd_reg_n != '0) begin
            push_cmd_c.addr  = rd_reg_n;
            push_c           = 1'b1;
        end
        if (push_c && fifo_full) begin
            push_c = 1'b0;
            drop_c = 1'b1;
        end
    end

    lcm_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   (push_cmd_c),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_c = cmd_t'(fifo_dout);
    assign pop_c  = (state_q == ST_IDLE) && !fifo_empty;
    assign ack_c  = (state_q == ST_BUS) && bus_ack;
    assign tmo_c  = (state_q == ST_BUS) && !bus_ack && (cnt_q == TIMEOUT - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (pop_c) state_d = ST_BUS;
            ST_BUS:       if (ack_c || tmo_c) state_d = bus_wr_q ? ST_IDLE : ST_RESP_HDR;
            ST_RESP_HDR:  if (out_lcm_data_ready) state_d = ST_RESP_DATA;
            ST_RESP_DATA: if (out_lcm_data_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req_d   = bus_req_q;
        bus_wr_d    = bus_wr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        timeout_d   = timeout_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_wr_d    = 1'b0;
        out_vwr_d   = 1'b0;
        cmd_drop_d  = drop_c;
        unique case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    bus_req_d   = 1'b1;
                    bus_wr_d    = head_c.is_wr;
                    bus_addr_d  = head_c.addr;
                    bus_wdata_d = head_c.wdata;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ack_c) begin
                    rdata_d   = bus_rdata;
                    timeout_d = 1'b0;
                    bus_req_d = 1'b0;
                end else if (tmo_c) begin
                    rdata_d   = TIMEOUT_FILL;
                    timeout_d = 1'b1;
                    bus_req_d = 1'b0;
                end
            end
            ST_RESP_HDR: begin
                if (out_lcm_data_ready) begin
                    out_data_d = make_hdr_beat(LMID, bus_addr_q);
                    out_wr_d   = 1'b1;
                end
            end
            ST_RESP_DATA: begin
                if (out_lcm_data_ready) begin
                    out_data_d  = make_data_beat(bus_addr_q, rdata_q);
                    out_wr_d    = 1'b1;
                    out_vwr_d   = 1'b1;
                    out_valid_d = !timeout_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            timeout_q   <= 1'b0;
            out_data_q  <= '0;
            out_wr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_vwr_q   <= 1'b0;
            cmd_drop_q  <= 1'b0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
            out_data_q  <= out_data_d;
            out_wr_q    <= out_wr_d;
            out_valid_q <= out_valid_d;
            out_vwr_q   <= out_vwr_d;
            cmd_drop_q  <= cmd_drop_d;
        end
    end

    assign bus_req               = bus_req_q;
    assign bus_wr                = bus_wr_q;
    assign bus_addr              = bus_addr_q;
    assign bus_wdata             = bus_wdata_q;
    assign out_lcm_data          = out_data_q;
    assign out_lcm_data_wr       = out_wr_q;
    assign out_lcm_data_valid    = out_valid_q;
    assign out_lcm_data_valid_wr = out_vwr_q;
    assign cmd_drop              = cmd_drop_q;
    // Decoded directly from flops so it tracks the queue in the same cycle.
    assign busy                  = (state_q != ST_IDLE) || !fifo_empty;

endmodule
